// File: rtl/sar_sequencer.sv
// sar_sequencer: successive-approximation conversion controller for a PWM-DAC/comparator ADC
module sar_sequencer #(
  parameter int WIDTH = 8,
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             compare,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid
);
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_t;
  state_t state;
  logic cmp_m, cmp_s;
  logic [WIDTH-1:0] mask, acc, acc_n;
  logic [CW-1:0] cnt;
  assign acc_n = acc | (cmp_s ? mask : '0);
  assign busy = state != IDLE;
  // two-flop synchronizer for the asynchronous comparator
  always_ff @(posedge CLOCK_50) begin
    cmp_m <= rst ? 1'b0 : compare;
    cmp_s <= rst ? 1'b0 : cmp_m;
  end
  // conversion sequencer: settle each trial code, then resolve one bit MSB first
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= IDLE;
      dac_code <= '0;
      result <= '0;
      acc <= '0;
      mask <= '0;
      cnt <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        SETTLE: begin
          if (cnt != 0) cnt <= cnt - 1'b1;
          else state <= DECIDE;
        end
        DECIDE: begin
          if (!mask[0]) begin
            acc <= acc_n;
            mask <= mask >> 1;
            dac_code <= acc_n | (mask >> 1);
            cnt <= CNT_INIT;
            state <= SETTLE;
          end else begin
            result <= acc_n;
            valid <= 1'b1;
            if (continuous) begin
              mask <= MSB;
              acc <= '0;
              dac_code <= MSB;
              cnt <= CNT_INIT;
              state <= SETTLE;
            end else begin
              dac_code <= acc_n;
              state <= IDLE;
            end
          end
        end
        default: begin
          if (start || continuous) begin
            mask <= MSB;
            acc <= '0;
            dac_code <= MSB;
            cnt <= CNT_INIT;
            state <= SETTLE;
          end else begin
            dac_code <= result;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sar_sequencer.sv
// tb_sar_sequencer: randomized self-checking bench against a binary-search reference model
module tb_sar_sequencer;
  logic clk = 0, rst = 1, start = 0, continuous = 0, compare = 0;
  logic [7:0] dac_code, result, vin = 0;
  logic busy, valid;
  int total = 0, bad = 0, nvalid;
  int vtime [8];
  logic [7:0] vres [8];
  logic [7:0] trials [8];
  logic busy0;

  sar_sequencer #(.WIDTH(8), .SETTLE_CYCLES(8)) dut (
    .CLOCK_50(clk), .rst(rst), .start(start), .continuous(continuous), .compare(compare),
    .dac_code(dac_code), .busy(busy), .result(result), .valid(valid)
  );

  always #5 clk = ~clk;
  // comparator: analog input vs DAC level, one clock of delay
  always @(posedge clk) compare <= (vin >= dac_code);

  // binary search: first nold decisions see a, later ones see b; stop after nbits decisions
  function automatic logic [7:0] sar_ref(input logic [7:0] a, input logic [7:0] b, input int nold, input int nbits);
    logic [7:0] acc = 0;
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] t = acc | (8'h80 >> i);
      if ((i < nold ? a : b) >= t) acc = t;
    end
    return acc;
  endfunction

  task automatic kick(input logic use_cont);
    if (use_cont) continuous = 1; else start = 1;
    @(posedge clk); #1;
    start = 0;
    trials[0] = dac_code;
    busy0 = busy;
  endtask

  task automatic watch(input int ncyc, input int p1, input int p2, input int vn, input logic [7:0] vv, input int cn);
    nvalid = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        if (nvalid < 8) begin vtime[nvalid] = n; vres[nvalid] = result; end
        nvalid++;
      end
      if (n < 72 && n % 9 == 0) trials[n/9] = dac_code;
      start = (n == p1 || n == p2);
      if (n == vn) vin = vv;
      if (n == cn) continuous = 0;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL reset_dac got=%h exp=00", dac_code); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    logic [7:0] exp;
    vin = 8'hA5;
    kick(0);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL single_busy_start got=%b exp=1", busy0); end
    watch(80, -1, -1, -1, 8'h00, -1);
    for (int j = 0; j < 8; j++) begin
      exp = sar_ref(vin, vin, 8, j) | (8'h80 >> j);
      total++; if (trials[j] !== exp) begin bad++; $display("FAIL single_trial%0d got=%h exp=%h", j, trials[j], exp); end
    end
    total++; if (nvalid !== 1) begin bad++; $display("FAIL single_nvalid got=%0d exp=1", nvalid); end
    total++; if (vtime[0] !== 72) begin bad++; $display("FAIL single_vtime got=%0d exp=72", vtime[0]); end
    total++; if (vres[0] !== 8'hA5) begin bad++; $display("FAIL single_result got=%h exp=a5", vres[0]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    total++; if (dac_code !== 8'hA5) begin bad++; $display("FAIL single_dac_hold got=%h exp=a5", dac_code); end
  endtask

  task automatic test_extremes;
    logic [7:0] vals [7];
    logic [7:0] exp;
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h80;
    for (int i = 3; i < 7; i++) vals[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 7; i++) begin
      vin = vals[i];
      exp = sar_ref(vin, vin, 8, 8);
      kick(0);
      watch(80, -1, -1, -1, 8'h00, -1);
      total++; if (nvalid !== 1 || vtime[0] !== 72) begin bad++; $display("FAIL conv_timing vin=%h got n=%0d t=%0d exp n=1 t=72", vin, nvalid, vtime[0]); end
      total++; if (vres[0] !== exp) begin bad++; $display("FAIL conv_result vin=%h got=%h exp=%h", vin, vres[0], exp); end
    end
  endtask

  task automatic test_back_to_back;
    vin = 8'h3C;
    kick(0);
    watch(150, 10, 40, -1, 8'h00, -1);
    total++; if (nvalid !== 1) begin bad++; $display("FAIL b2b_nvalid got=%0d exp=1", nvalid); end
    total++; if (vtime[0] !== 72) begin bad++; $display("FAIL b2b_vtime got=%0d exp=72", vtime[0]); end
    total++; if (vres[0] !== 8'h3C) begin bad++; $display("FAIL b2b_result got=%h exp=3c", vres[0]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_continuous;
    logic [7:0] exp [4];
    exp[0] = sar_ref(8'h12, 8'h12, 8, 8);
    exp[1] = sar_ref(8'h12, 8'hE7, 4, 8);
    exp[2] = sar_ref(8'hE7, 8'hE7, 8, 8);
    exp[3] = exp[2];
    vin = 8'h12;
    kick(1);
    watch(320, -1, -1, 110, 8'hE7, 250);
    total++; if (nvalid !== 4) begin bad++; $display("FAIL cont_nvalid got=%0d exp=4", nvalid); end
    for (int i = 0; i < 4; i++) begin
      total++; if (vtime[i] !== 72 * (i + 1)) begin bad++; $display("FAIL cont_vtime%0d got=%0d exp=%0d", i, vtime[i], 72 * (i + 1)); end
      total++; if (vres[i] !== exp[i]) begin bad++; $display("FAIL cont_result%0d got=%h exp=%h", i, vres[i], exp[i]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    vin = 8'h55;
    kick(0);
    watch(30, -1, -1, -1, 8'h00, -1);
    rst = 1;
    @(posedge clk); #1;
    total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL rmid_dac got=%h exp=00", dac_code); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL rmid_result got=%h exp=00", result); end
    total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_flags got=%b%b exp=00", valid, busy); end
    rst = 0;
    watch(80, -1, -1, -1, 8'h00, -1);
    total++; if (nvalid !== 0) begin bad++; $display("FAIL rmid_no_valid got=%0d exp=0", nvalid); end
    kick(0);
    watch(80, -1, -1, -1, 8'h00, -1);
    total++; if (nvalid !== 1 || vtime[0] !== 72) begin bad++; $display("FAIL rmid_restart_timing got n=%0d t=%0d exp n=1 t=72", nvalid, vtime[0]); end
    total++; if (vres[0] !== 8'h55) begin bad++; $display("FAIL rmid_restart_result got=%h exp=55", vres[0]); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_extremes;
    test_back_to_back;
    test_continuous;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
